ipv4_hdr_gen: RTL

Parametrised IPv4 header generator for the UDP transmit path. On a start pulse it builds a complete 20-byte IPv4 header and writes it byte-by-byte into the header buffer:
- total length from the payload length;
- source IP from a register;
- destination IP from a NUM_DEST-entry table;
- a per-packet identification counter;
- a freshly computed header checksum.

It replaces the fixed single-destination generator, with run-time configurable addresses, a per-packet ID and input error checking.

---
 rtl/ipv4_hdr_gen.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ipv4_hdr_gen.sv
// IPv4 header generator: builds a 20-byte header (len, src, dst, id, checksum) and streams it byte-wise.
// Latency: start accepted at edge 0 -> bytes 0..19 in cycles 12..31, o_done in cycle 32.
// Backpressure: none; a start while busy is dropped, an invalid start is rejected with an o_err pulse.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               start request (IDLE only), with i_payload_len and i_dest_sel
//   i_cfg_we/sel/ip       config write: sel 0 = source IP, sel k (1..NUM_DEST) = dest entry k-1
//   o_hdr_idx/byte/we     header buffer write port (offset 0..19)
//   o_busy, o_done, o_err status: busy window, completion pulse, reject pulse
module ipv4_hdr_gen #(
    parameter int          NUM_DEST   = 4,
    parameter int          DEST_W     = 2,
    parameter logic [7:0]  TTL        = 8'h40,
    parameter logic [7:0]  PROTOCOL   = 8'h11,
    parameter logic [31:0] INIT_SRCIP = 32'hC0A80104,
    parameter logic [31:0] INIT_DSTIP = 32'hC0A80105
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [15:0]       i_payload_len,
    input  logic [DEST_W-1:0] i_dest_sel,
    input  logic              i_cfg_we,
    input  logic [4:0]        i_cfg_sel,
    input  logic [31:0]       i_cfg_ip,
    output logic [4:0]        o_hdr_idx,
    output logic [7:0]        o_hdr_byte,
    output logic              o_hdr_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SUM   = 3'd1,
        S_FOLD  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] NUM_DEST_U = NUM_DEST;
    localparam logic [15:0] MAX_PAYLOAD = 16'd65515;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [16:0]  acc_q, acc_d;
    logic [15:0]  cs_q, cs_d;
    logic [15:0]  id_q, id_d;
    logic [15:0]  len_q, len_d;
    logic [15:0]  pkt_id_q, pkt_id_d;
    logic [31:0]  src_q, src_d;
    logic [31:0]  dst_q, dst_d;
    logic [31:0]  src_cfg_q, src_cfg_d;
    logic [31:0]  dest_q [NUM_DEST];
    logic [31:0]  dest_d [NUM_DEST];
    logic [4:0]   hdr_idx_q, hdr_idx_d;
    logic [7:0]   hdr_byte_q, hdr_byte_d;
    logic         hdr_we_q, hdr_we_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [31:0]  dest_sel_ext;
    logic [31:0]  dst_pick;
    logic         start_bad;
    logic [15:0]  sum_word;
    logic [7:0]   cur_byte;
    logic [16:0]  fold_sum;

    assign dest_sel_ext = {{(32-DEST_W){1'b0}}, i_dest_sel};
    assign start_bad    = (i_payload_len > MAX_PAYLOAD) || (dest_sel_ext >= NUM_DEST_U);
    assign fold_sum     = {1'b0, acc_q[15:0]} + {16'b0, acc_q[16]};

    // Compare-and-select rather than direct indexing so non-power-of-two tables
    // never see an out-of-range read.
    always_comb begin
        dst_pick = INIT_DSTIP;
        for (int k = 0; k < NUM_DEST; k++) begin
            if (dest_sel_ext == 32'(k)) begin
                dst_pick = dest_q[k];
            end
        end
    end

    // Header words in transmit order, checksum slot (word 5) taken as zero.
    always_comb begin
        sum_word = 16'h0000;
        case (cnt_q)
            5'd0:    sum_word = 16'h4500;
            5'd1:    sum_word = len_q;
            5'd2:    sum_word = pkt_id_q;
            5'd3:    sum_word = 16'h4000;
            5'd4:    sum_word = {TTL, PROTOCOL};
            5'd6:    sum_word = src_q[31:16];
            5'd7:    sum_word = src_q[15:0];
            5'd8:    sum_word = dst_q[31:16];
            5'd9:    sum_word = dst_q[15:0];
            default: sum_word = 16'h0000;
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        case (cnt_q)
            5'd0:    cur_byte = 8'h45;
            5'd1:    cur_byte = 8'h00;
            5'd2:    cur_byte = len_q[15:8];
            5'd3:    cur_byte = len_q[7:0];
            5'd4:    cur_byte = pkt_id_q[15:8];
            5'd5:    cur_byte = pkt_id_q[7:0];
            5'd6:    cur_byte = 8'h40;
            5'd7:    cur_byte = 8'h00;
            5'd8:    cur_byte = TTL;
            5'd9:    cur_byte = PROTOCOL;
            5'd10:   cur_byte = cs_q[15:8];
            5'd11:   cur_byte = cs_q[7:0];
            5'd12:   cur_byte = src_q[31:24];
            5'd13:   cur_byte = src_q[23:16];
            5'd14:   cur_byte = src_q[15:8];
            5'd15:   cur_byte = src_q[7:0];
            5'd16:   cur_byte = dst_q[31:24];
            5'd17:   cur_byte = dst_q[23:16];
            5'd18:   cur_byte = dst_q[15:8];
            5'd19:   cur_byte = dst_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        cs_d       = cs_q;
        id_d       = id_q;
        len_d      = len_q;
        pkt_id_d   = pkt_id_q;
        src_d      = src_q;
        dst_d      = dst_q;
        src_cfg_d  = src_cfg_q;
        dest_d     = dest_q;
        hdr_idx_d  = 5'd0;
        hdr_byte_d = 8'h00;
        hdr_we_d   = 1'b0;
        // Status is derived from the registered state, so it trails the state by one cycle.
        busy_d     = (state_q != S_IDLE);
        done_d     = 1'b0;
        err_d      = 1'b0;

        // Config table updates run in every state; in-flight packets use latched copies.
        if (i_cfg_we) begin
            if (i_cfg_sel == 5'd0) begin
                src_cfg_d = i_cfg_ip;
            end
            for (int k = 0; k < NUM_DEST; k++) begin
                if ({27'b0, i_cfg_sel} == 32'(k + 1)) begin
                    dest_d[k] = i_cfg_ip;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        // Reads the pre-write register values, so a coincident config write is not seen.
                        len_d    = i_payload_len + 16'd20;
                        pkt_id_d = id_q;
                        src_d    = src_cfg_q;
                        dst_d    = dst_pick;
                        acc_d    = 17'd0;
                        cnt_d    = 5'd0;
                        state_d  = S_SUM;
                    end
                end
            end
            S_SUM: begin
                // End-around carry folded in every step keeps the accumulator at 17 bits.
                acc_d = {1'b0, acc_q[15:0]} + {1'b0, sum_word} + {16'b0, acc_q[16]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd9) begin
                    cnt_d   = 5'd0;
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                acc_d   = fold_sum;
                cs_d    = ~fold_sum[15:0];
                cnt_d   = 5'd0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                hdr_we_d   = 1'b1;
                hdr_idx_d  = cnt_q;
                hdr_byte_d = cur_byte;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == 5'd19) begin
                    cnt_d   = 5'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                id_d    = id_q + 16'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            acc_q      <= 17'd0;
            cs_q       <= 16'd0;
            id_q       <= 16'd0;
            len_q      <= 16'd0;
            pkt_id_q   <= 16'd0;
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
            src_cfg_q  <= INIT_SRCIP;
            for (int k = 0; k < NUM_DEST; k++) begin
                dest_q[k] <= INIT_DSTIP;
            end
            hdr_idx_q  <= 5'd0;
            hdr_byte_q <= 8'h00;
            hdr_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            cs_q       <= cs_d;
            id_q       <= id_d;
            len_q      <= len_d;
            pkt_id_q   <= pkt_id_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            src_cfg_q  <= src_cfg_d;
            dest_q     <= dest_d;
            hdr_idx_q  <= hdr_idx_d;
            hdr_byte_q <= hdr_byte_d;
            hdr_we_q   <= hdr_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_hdr_idx  = hdr_idx_q;
    assign o_hdr_byte = hdr_byte_q;
    assign o_hdr_we   = hdr_we_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule
